// File: rtl/complex_variable_moving_sum.sv
// Moving-window sum (or power-of-two average) of complex samples over a
// run-time selectable window L = 2**cfg_log2, with one registered output stage.
module complex_variable_moving_sum #(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [$clog2(MAX_LOG2+1)-1:0] cfg_log2,
  input  logic                          cfg_average,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [2*WIDTH-1:0]            s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [2*(WIDTH+MAX_LOG2)-1:0] m_data,
  output logic                          m_full
);
  localparam int CFG_W = $clog2(MAX_LOG2 + 1);
  localparam int DEPTH = 2**MAX_LOG2;
  localparam int AW    = WIDTH + MAX_LOG2;
  localparam int CW    = MAX_LOG2 + 1;
  localparam logic [CFG_W-1:0] MAX_CFG = CFG_W'(MAX_LOG2);

  logic [CFG_W-1:0]        log2_q;
  logic                    avg_q;
  logic [CFG_W-1:0]        cfg_clamped;
  logic [2*WIDTH-1:0]      mem [DEPTH];
  logic [MAX_LOG2-1:0]     wptr;
  logic [MAX_LOG2-1:0]     rptr;
  logic [CW-1:0]           fill;
  logic [CW-1:0]           fill_next;
  logic [CW-1:0]           win_len;
  logic                    window_full;
  logic                    in_xfer;
  logic [2*WIDTH-1:0]      old_sample;
  logic signed [WIDTH-1:0] new_re;
  logic signed [WIDTH-1:0] new_im;
  logic signed [WIDTH-1:0] old_re;
  logic signed [WIDTH-1:0] old_im;
  logic signed [AW-1:0]    acc_re;
  logic signed [AW-1:0]    acc_im;
  logic signed [AW-1:0]    nxt_re;
  logic signed [AW-1:0]    nxt_im;
  logic signed [AW-1:0]    out_re;
  logic signed [AW-1:0]    out_im;

  assign cfg_clamped = (cfg_log2 > MAX_CFG) ? MAX_CFG : cfg_log2;
  assign s_ready     = !reset && !clear && (!m_valid || m_ready);
  assign in_xfer     = s_valid && s_ready;

  // The sample leaving the window is only subtracted once L samples are held;
  // with L == DEPTH the read slot equals the write slot and is read before overwrite.
  assign win_len     = CW'(1) << log2_q;
  assign window_full = (fill == win_len);
  assign rptr        = wptr - win_len[MAX_LOG2-1:0];
  assign old_sample  = window_full ? mem[rptr] : '0;
  assign fill_next   = window_full ? fill : fill + CW'(1);

  assign new_re = s_data[WIDTH-1:0];
  assign new_im = s_data[2*WIDTH-1:WIDTH];
  assign old_re = old_sample[WIDTH-1:0];
  assign old_im = old_sample[2*WIDTH-1:WIDTH];

  assign nxt_re = acc_re + AW'(new_re) - AW'(old_re);
  assign nxt_im = acc_im + AW'(new_im) - AW'(old_im);
  assign out_re = avg_q ? (nxt_re >>> log2_q) : nxt_re;
  assign out_im = avg_q ? (nxt_im >>> log2_q) : nxt_im;

  // Window state and output register; reset and clear both flush and reload config.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      log2_q  <= cfg_clamped;
      avg_q   <= cfg_average;
      acc_re  <= '0;
      acc_im  <= '0;
      fill    <= '0;
      wptr    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_full  <= 1'b0;
    end else if (in_xfer) begin
      acc_re  <= nxt_re;
      acc_im  <= nxt_im;
      fill    <= fill_next;
      wptr    <= wptr + 1'b1;
      m_valid <= 1'b1;
      m_data  <= {out_im, out_re};
      m_full  <= (fill_next == win_len);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      mem[wptr] <= s_data;
    end
  end

endmodule

// File: doc/complex_variable_moving_sum.md
COMPLEX_VARIABLE_MOVING_SUM -- requirements
Module: complex_variable_moving_sum

Interface
REQ-001 Parameter WIDTH, default 16: signed bit width of each real/imag input component.
REQ-002 Parameter MAX_LOG2, default 4: log2 of the maximum window length; buffer depth 2**MAX_LOG2.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush of window state; samples cfg_log2 and cfg_average.
REQ-006 cfg_log2  input  $clog2(MAX_LOG2+1)  window length L = 2**cfg_log2; values above MAX_LOG2 clamp to MAX_LOG2.
REQ-007 cfg_average  input  1  0 = output the sum; 1 = output the sum arithmetically shifted right by cfg_log2.
REQ-008 s_valid  input  1  input sample valid.
REQ-009 s_ready  output  1  block accepts a sample this cycle.
REQ-010 s_data  input  2*WIDTH  signed sample; real in [WIDTH-1:0], imag in [2*WIDTH-1:WIDTH].
REQ-011 m_valid  output  1  output result valid.
REQ-012 m_ready  input  1  downstream accepts the result.
REQ-013 m_data  output  2*(WIDTH+MAX_LOG2)  signed result; real in low half, imag in high half.
REQ-014 m_full  output  1  qualifies m_data; 1 when the window held L real samples at that result.

Function
REQ-015 Transfer in = s_valid && s_ready; transfer out = m_valid && m_ready.
REQ-016 s_ready = !reset && !clear && (!m_valid || m_ready); single output register, no skid buffer.
REQ-017 Each input transfer produces exactly one result; result appears on m_valid the cycle after acceptance (latency 1).
REQ-018 m_data and m_full held stable while m_valid && !m_ready.
REQ-019 Per component: acc_next = acc + x[n] - x[n-L]; x[n-L] = 0 while fill count < L.
REQ-020 Samples stored in circular buffer of 2**MAX_LOG2 entries; write pointer advances on each input transfer, wraps modulo depth; x[n-L] read from (wptr - L) mod depth.
REQ-021 Accumulators are WIDTH+MAX_LOG2 bits, two's complement, sign-extended inputs; no overflow possible for any L.
REQ-022 Fill counter saturates at L; m_full of a result = 1 iff fill count after that sample equals L.
REQ-023 cfg_average=1: each component output = acc >>> L_log2 (arithmetic, rounds toward minus infinity), sign-extended to full width; accumulator itself unshifted.
REQ-024 Active cfg_log2/cfg_average are registered copies loaded on reset or clear; changes on inputs at other times have no effect.
REQ-025 clear: accumulators, fill counter, write pointer, m_valid, m_full zeroed next cycle; any pending output discarded; buffer contents need not be cleared.
REQ-026 clear and s_valid same cycle: clear wins, s_ready = 0, no sample accepted.
REQ-027 Real and imag paths share all control; identical timing.

Reset
REQ-028 During reset: s_ready = 0; after reset: m_valid = 0, m_data = 0, m_full = 0, accumulators, fill counter, write pointer = 0.
REQ-029 Reset mid-stream discards pending output and window history; first post-reset result equals first post-reset input (or its shift).
REQ-030 Reset has priority over clear and all transfers.

Verification
REQ-031 cfg_log2=2, sum, m_ready=1, real 1,2,3,4,5, imag 0 -> real results 1,3,6,10,14; imag 0; m_full 0,0,0,1,1.
REQ-032 cfg_log2=2, average, imag -8 x5, real 0 -> imag results -2,-4,-6,-8,-8; real 0; m_full on 4th and 5th.
REQ-033 s_valid held high, m_ready low 3 cycles after first result -> s_ready low those cycles, m_data stable, no sample lost or duplicated after release.
REQ-034 Mid-stream clear with cfg_log2 changed 2 -> 0 -> next results equal inputs exactly, m_full=1 from the first.
REQ-035 WIDTH=16, cfg_log2=4, 20 real samples of -32768 -> 16th..20th results -524288, m_full=1, no wrap error across buffer wrap.
REQ-036 reset asserted 1 cycle with m_valid=1 pending -> m_valid=0, m_data=0 next cycle; next input 7 yields result 7.
